// File: rtl/dmem_pkg.sv
// Shared definitions for the RNBIP data memory / hardware stack: operation
// encodings and the request-vector decode used by data_mem_stack.
package dmem_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_NONE    = 3'd0;
   localparam op_t OP_RD      = 3'd1;
   localparam op_t OP_WR      = 3'd2;
   localparam op_t OP_PUSH    = 3'd3;
   localparam op_t OP_POP     = 3'd4;
   localparam op_t OP_SPLD    = 3'd5;
   localparam op_t OP_ILLEGAL = 3'd6;

   // Request bits are ordered {sp_ld, pop, push, wr, rd}; more than one set is illegal.
   function automatic op_t decode_op(input logic [4:0] req);
      op_t op;
      case (req)
         5'b00000: op = OP_NONE;
         5'b00001: op = OP_RD;
         5'b00010: op = OP_WR;
         5'b00100: op = OP_PUSH;
         5'b01000: op = OP_POP;
         5'b10000: op = OP_SPLD;
         default:  op = OP_ILLEGAL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/data_mem_stack_if.sv
// Bus between the decode/control unit (master) and data_mem_stack (slave).
// DMEM_PARITY_EN adds the par_err response signal.
interface data_mem_stack_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] ptr_in;
   logic [DATA_W-1:0] data_in;
   logic              rd;
   logic              wr;
   logic              push;
   logic              pop;
   logic              sp_ld;
   logic [ADDR_W-1:0] sp_ld_val;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic [ADDR_W-1:0] sp_out;
   logic              stack_empty;
   logic              stack_full;
   logic              err_ovf;
   logic              err_unf;
   logic              cmd_err;
`ifdef DMEM_PARITY_EN
   logic              par_err;
`endif

   modport master (
      output ptr_in, data_in, rd, wr, push, pop, sp_ld, sp_ld_val,
      input  data_out, rd_valid, sp_out, stack_empty, stack_full,
             err_ovf, err_unf, cmd_err
`ifdef DMEM_PARITY_EN
      , input par_err
`endif
   );

   modport slave (
      input  ptr_in, data_in, rd, wr, push, pop, sp_ld, sp_ld_val,
      output data_out, rd_valid, sp_out, stack_empty, stack_full,
             err_ovf, err_unf, cmd_err
`ifdef DMEM_PARITY_EN
      , output par_err
`endif
   );
endinterface

// File: rtl/dmem_ram.sv
// Single-array data memory with one synchronous write port and one synchronous
// read port; the read register resets to zero but the array contents do not.
module dmem_ram #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [2**ADDR_W];
   logic [WORD_W-1:0] rdata_d;
   logic [WORD_W-1:0] rdata_q;

   // A write coinciding with reset is dropped so a reset mid-op leaves memory intact.
   always_ff @(posedge clk) begin
      if (we && rst_n) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_stack.sv
// RNBIP data memory with built-in downward-growing hardware stack.
// Optional DMEM_PARITY_EN stores an even-parity bit per word and reports par_err.
module data_mem_stack
   import dmem_pkg::*;
#(
   parameter int              DATA_W   = 8,
   parameter int              ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] SP_RESET = '1,
   parameter logic [ADDR_W-1:0] SP_LIMIT = '0
) (
   input logic             clk,
   input logic             rst_n,
   data_mem_stack_if.slave bus
);

`ifdef DMEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif

   localparam logic [ADDR_W-1:0] SP_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LIMIT_M1 = SP_LIMIT - SP_ONE;
   // When the full point would alias the empty point, give up one slot so the two stay distinct.
   localparam logic [ADDR_W-1:0] SP_FULL  = (LIMIT_M1 == SP_RESET) ? SP_LIMIT : LIMIT_M1;

   op_t               op;
   logic              stack_empty;
   logic              stack_full;
   logic [ADDR_W-1:0] sp_d, sp_q;
   logic              rd_valid_d, rd_valid_q;
   logic              err_ovf_d, err_ovf_q;
   logic              err_unf_d, err_unf_q;
   logic              cmd_err_d, cmd_err_q;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_waddr, ram_raddr;
   logic [WORD_W-1:0] ram_wdata, ram_rdata;

   assign op          = decode_op({bus.sp_ld, bus.pop, bus.push, bus.wr, bus.rd});
   assign stack_empty = (sp_q == SP_RESET);
   assign stack_full  = (sp_q == SP_FULL);

   always_comb begin
      sp_d       = sp_q;
      rd_valid_d = 1'b0;
      err_ovf_d  = err_ovf_q;
      err_unf_d  = err_unf_q;
      cmd_err_d  = 1'b0;
      ram_we     = 1'b0;
      ram_waddr  = bus.ptr_in;
      ram_re     = 1'b0;
      ram_raddr  = bus.ptr_in;
      case (op)
         OP_RD: begin
            ram_re     = 1'b1;
            rd_valid_d = 1'b1;
         end
         OP_WR: begin
            ram_we = 1'b1;
         end
         OP_PUSH: begin
            if (stack_full) begin
               err_ovf_d = 1'b1;
            end else begin
               ram_we    = 1'b1;
               ram_waddr = sp_q;
               sp_d      = sp_q - SP_ONE;
            end
         end
         OP_POP: begin
            if (stack_empty) begin
               err_unf_d = 1'b1;
            end else begin
               sp_d       = sp_q + SP_ONE;
               ram_re     = 1'b1;
               ram_raddr  = sp_q + SP_ONE;
               rd_valid_d = 1'b1;
            end
         end
         OP_SPLD: begin
            sp_d = bus.sp_ld_val;
         end
         OP_ILLEGAL: begin
            cmd_err_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q       <= SP_RESET;
         rd_valid_q <= 1'b0;
         err_ovf_q  <= 1'b0;
         err_unf_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         sp_q       <= sp_d;
         rd_valid_q <= rd_valid_d;
         err_ovf_q  <= err_ovf_d;
         err_unf_q  <= err_unf_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   dmem_ram #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

`ifdef DMEM_PARITY_EN
   assign ram_wdata   = {^bus.data_in, bus.data_in};
   assign bus.par_err = rd_valid_q & (^ram_rdata);
`else
   assign ram_wdata   = bus.data_in;
`endif

   assign bus.data_out    = ram_rdata[DATA_W-1:0];
   assign bus.rd_valid    = rd_valid_q;
   assign bus.sp_out      = sp_q;
   assign bus.stack_empty = stack_empty;
   assign bus.stack_full  = stack_full;
   assign bus.err_ovf     = err_ovf_q;
   assign bus.err_unf     = err_unf_q;
   assign bus.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_data_mem_stack.sv
// Self-checking bench for data_mem_stack: directed cases plus randomized ops
// against an occupancy-based stack/memory model. Covers DMEM_PARITY_EN when defined.
module tb_data_mem_stack;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   data_mem_stack_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   data_mem_stack #(.DATA_W(8), .ADDR_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: default geometry gives 255 usable slots, empty at SP=FF.
   logic [7:0] m_mem [256];
   bit         m_known [256];
   logic [7:0] m_sp;
   logic [7:0] m_data;
   bit         m_data_known;
   bit         m_rd_valid, m_cmd_err, m_ovf, m_unf, m_par_err;
   int         compared   = 0;
   int         mismatched = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int occupancy();
      return 255 - int'(m_sp);
   endfunction

   task automatic modelReset();
      m_sp         = 8'hFF;
      m_data       = 8'h00;
      m_data_known = 1'b1;
      m_rd_valid   = 1'b0;
      m_cmd_err    = 1'b0;
      m_ovf        = 1'b0;
      m_unf        = 1'b0;
      m_par_err    = 1'b0;
   endtask

   task automatic modelStep(input bit r, w, pu, po, sl,
                            input logic [7:0] ptr, din, slv);
      int n;
      n = int'(r) + int'(w) + int'(pu) + int'(po) + int'(sl);
      m_rd_valid = 1'b0;
      m_cmd_err  = 1'b0;
      m_par_err  = 1'b0;
      if (n > 1) begin
         m_cmd_err = 1'b1;
      end else if (r) begin
         m_data       = m_mem[ptr];
         m_data_known = m_known[ptr];
         m_rd_valid   = 1'b1;
      end else if (w) begin
         m_mem[ptr]   = din;
         m_known[ptr] = 1'b1;
      end else if (pu) begin
         if (occupancy() == 255) begin
            m_ovf = 1'b1;
         end else begin
            m_mem[m_sp]   = din;
            m_known[m_sp] = 1'b1;
            m_sp          = m_sp - 8'd1;
         end
      end else if (po) begin
         if (occupancy() == 0) begin
            m_unf = 1'b1;
         end else begin
            m_sp         = m_sp + 8'd1;
            m_data       = m_mem[m_sp];
            m_data_known = m_known[m_sp];
            m_rd_valid   = 1'b1;
         end
      end else if (sl) begin
         m_sp = slv;
      end
   endtask

   task automatic checkAll(input string where);
      checkOutput({where, ":sp_out"},      32'(bus.sp_out),      32'(m_sp));
      checkOutput({where, ":stack_empty"}, 32'(bus.stack_empty), 32'(occupancy() == 0));
      checkOutput({where, ":stack_full"},  32'(bus.stack_full),  32'(occupancy() == 255));
      checkOutput({where, ":rd_valid"},    32'(bus.rd_valid),    32'(m_rd_valid));
      checkOutput({where, ":cmd_err"},     32'(bus.cmd_err),     32'(m_cmd_err));
      checkOutput({where, ":err_ovf"},     32'(bus.err_ovf),     32'(m_ovf));
      checkOutput({where, ":err_unf"},     32'(bus.err_unf),     32'(m_unf));
      if (m_data_known) begin
         checkOutput({where, ":data_out"}, 32'(bus.data_out),    32'(m_data));
      end
`ifdef DMEM_PARITY_EN
      checkOutput({where, ":par_err"},     32'(bus.par_err),     32'(m_par_err));
`endif
   endtask

   task automatic clearInputs();
      bus.rd        = 1'b0;
      bus.wr        = 1'b0;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.sp_ld     = 1'b0;
      bus.ptr_in    = 8'h00;
      bus.data_in   = 8'h00;
      bus.sp_ld_val = 8'h00;
   endtask

   task automatic applyStimulus(input string where, input bit r, w, pu, po, sl,
                                input logic [7:0] ptr, din, slv);
      @(negedge clk);
      bus.rd        = r;
      bus.wr        = w;
      bus.push      = pu;
      bus.pop       = po;
      bus.sp_ld     = sl;
      bus.ptr_in    = ptr;
      bus.data_in   = din;
      bus.sp_ld_val = slv;
      @(posedge clk);
      modelStep(r, w, pu, po, sl, ptr, din, slv);
      #1;
      clearInputs();
      checkAll(where);
   endtask

   // Reset asserted at a negedge while optionally requesting a write that must be dropped.
   task automatic doReset(input string where, input bit with_wr, input logic [7:0] ptr, din);
      @(negedge clk);
      rst_n      = 1'b0;
      bus.wr     = with_wr;
      bus.ptr_in = ptr;
      bus.data_in = din;
      modelReset();
      #1;
      checkAll({where, ":async"});
      @(posedge clk);
      #1;
      clearInputs();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkAll({where, ":release"});
   endtask

   initial begin
      bit         r, w, pu, po, sl;
      int         sel;
      logic [7:0] ptr, din, slv;

      for (int i = 0; i < 256; i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = 8'h00;
      end
      clearInputs();
      rst_n = 1'b1;
      modelReset();

      doReset("reset", 1'b0, 8'h00, 8'h00);

      applyStimulus("wr10",  0, 1, 0, 0, 0, 8'h10, 8'hA5, 8'h00);
      applyStimulus("rd10",  1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00);
      applyStimulus("hold",  0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

      applyStimulus("push11", 0, 0, 1, 0, 0, 8'h00, 8'h11, 8'h00);
      applyStimulus("push22", 0, 0, 1, 0, 0, 8'h00, 8'h22, 8'h00);
      applyStimulus("push33", 0, 0, 1, 0, 0, 8'h00, 8'h33, 8'h00);
      applyStimulus("pop1",   0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus("pop2",   0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus("pop3",   0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);

      applyStimulus("pop_empty", 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus("spld00",    0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
      applyStimulus("push_full", 0, 0, 1, 0, 0, 8'h00, 8'h77, 8'h00);
      applyStimulus("spldFF",    0, 0, 0, 0, 1, 8'h00, 8'h00, 8'hFF);

      applyStimulus("rd_push",   1, 0, 1, 0, 0, 8'h10, 8'hEE, 8'h00);
      applyStimulus("after_ill", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      applyStimulus("rd_ff",     1, 0, 0, 0, 0, 8'hFF, 8'h00, 8'h00);

      doReset("reset_mid_wr", 1'b1, 8'h10, 8'h5A);
      applyStimulus("rd10_kept", 1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00);

`ifdef DMEM_PARITY_EN
      applyStimulus("par_wr",   0, 1, 0, 0, 0, 8'h10, 8'hA5, 8'h00);
      dut.u_ram.mem_q[8'h10][8] = ~dut.u_ram.mem_q[8'h10][8];
      applyStimulus("par_rd_pre", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      bus.rd     = 1'b1;
      bus.ptr_in = 8'h10;
      @(posedge clk);
      modelStep(1, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00);
      m_par_err = 1'b1;
      #1;
      clearInputs();
      checkAll("par_rd");
      applyStimulus("par_after", 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
`endif

      for (int k = 0; k < 600; k++) begin
         {r, w, pu, po, sl} = 5'b00000;
         ptr = 8'($urandom_range(0, 15));
         din = 8'($urandom);
         slv = 8'h00;
         sel = $urandom_range(0, 19);
         if (sel < 4)       r  = 1'b1;
         else if (sel < 7)  w  = 1'b1;
         else if (sel < 11) pu = 1'b1;
         else if (sel < 15) po = 1'b1;
         else if (sel == 15) begin
            sl = 1'b1;
            case ($urandom_range(0, 4))
               0:       slv = 8'hFF;
               1:       slv = 8'hFE;
               2:       slv = 8'h00;
               3:       slv = 8'h01;
               default: slv = 8'($urandom);
            endcase
         end else if (sel == 16) begin
            int a, b;
            logic [4:0] mask;
            a    = $urandom_range(0, 4);
            b    = (a + 1 + $urandom_range(0, 3)) % 5;
            mask = 5'b00000;
            mask[a] = 1'b1;
            mask[b] = 1'b1;
            {sl, po, pu, w, r} = mask;
         end
         applyStimulus("rand", r, w, pu, po, sl, ptr, din, slv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
